// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit.
//   state_t : FSM states (FETCH, DECODE, EXECUTE, MEM, HALT), exported on o_state.
//   flow_t  : how an instruction leaves EXECUTE (sequential, load, CBZ, B, halt).
//   OP_*    : opcode field values, each compared against its own field width.
//   FS_*    : ALU function-select codes.
//   ctrl_t  : decoded control word registered in DECODE and driven in EXECUTE/MEM.
package control_unit_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    FLOW_SEQ  = 3'd0,
    FLOW_LOAD = 3'd1,
    FLOW_CBZ  = 3'd2,
    FLOW_B    = 3'd3,
    FLOW_HALT = 3'd4
  } flow_t;

  // 11-bit opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  // 10-bit opcodes, instr[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b10_0100_0100;
  localparam logic [9:0]  OP_SUBI = 10'b11_0100_0100;
  // 8-bit opcode, instr[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  // 6-bit opcode, instr[31:26]
  localparam logic [5:0]  OP_B    = 6'b00_0101;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00001;
  localparam logic [4:0] FS_PASSB = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic        data_mux;
    logic        reg_w;
    logic        ram_w;
    logic        mem_r;
    logic        b_sel;
    flow_t       flow;
  } ctrl_t;

endpackage

// File: rtl/control_unit_instr_decode.sv
// instr_decode: purely combinational decode of the instruction register.
//   i_ir      : latched instruction word
//   o_ctrl    : control word as it should appear during EXECUTE
//   o_illegal : word is not zero and matches no supported opcode
// For CBZ and B, k carries the byte offset (imm<<2) used for the pc update.
module instr_decode
  import control_unit_pkg::*;
(
  input  logic [31:0] i_ir,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  logic [4:0]  w_rd, w_rn, w_rm;
  logic [63:0] w_imm12_z, w_imm9_s, w_imm19_s, w_imm26_s;

  assign w_rd      = i_ir[4:0];
  assign w_rn      = i_ir[9:5];
  assign w_rm      = i_ir[20:16];
  assign w_imm12_z = {52'd0, i_ir[21:10]};
  assign w_imm9_s  = {{55{i_ir[20]}}, i_ir[20:12]};
  assign w_imm19_s = {{43{i_ir[23]}}, i_ir[23:5], 2'b00};
  assign w_imm26_s = {{36{i_ir[25]}}, i_ir[25:0], 2'b00};

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    if (i_ir == 32'd0) begin
      o_ctrl.flow = FLOW_HALT;
    end else begin
      case (i_ir[31:21])
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          o_ctrl.da    = w_rd;
          o_ctrl.sa    = w_rn;
          o_ctrl.sb    = w_rm;
          o_ctrl.reg_w = 1'b1;
          o_ctrl.fs    = (i_ir[31:21] == OP_ADD) ? FS_ADD :
                         (i_ir[31:21] == OP_SUB) ? FS_SUB :
                         (i_ir[31:21] == OP_AND) ? FS_AND : FS_ORR;
        end
        OP_LDUR, OP_STUR: begin
          // Rt sits in the Rd slot: destination for a load, data for a store.
          o_ctrl.da    = w_rd;
          o_ctrl.sa    = w_rn;
          o_ctrl.sb    = w_rd;
          o_ctrl.fs    = FS_ADD;
          o_ctrl.b_sel = 1'b1;
          o_ctrl.k     = w_imm9_s;
          if (i_ir[31:21] == OP_LDUR) begin
            o_ctrl.mem_r = 1'b1;
            o_ctrl.flow  = FLOW_LOAD;
          end else begin
            o_ctrl.ram_w = 1'b1;
          end
        end
        default: begin
          if (i_ir[31:22] == OP_ADDI || i_ir[31:22] == OP_SUBI) begin
            o_ctrl.da    = w_rd;
            o_ctrl.sa    = w_rn;
            o_ctrl.fs    = (i_ir[31:22] == OP_ADDI) ? FS_ADD : FS_SUB;
            o_ctrl.b_sel = 1'b1;
            o_ctrl.k     = w_imm12_z;
            o_ctrl.reg_w = 1'b1;
          end else if (i_ir[31:24] == OP_CBZ) begin
            o_ctrl.sb   = w_rd;
            o_ctrl.fs   = FS_PASSB;
            o_ctrl.k    = w_imm19_s;
            o_ctrl.flow = FLOW_CBZ;
          end else if (i_ir[31:26] == OP_B) begin
            o_ctrl.k    = w_imm26_s;
            o_ctrl.flow = FLOW_B;
          end else begin
            o_illegal = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEM/HALT sequencer.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   instr, instr_valid  : instruction word and its qualifier (used only in FETCH)
//   status              : datapath flags {V,C,N,Z}; only Z (bit 0) is consumed
//   instr_req, pc       : instruction request and byte program counter
//   k, DA, SA, SB, FS   : immediate/offset, register selects, ALU function
//   dataMux, regW, ramW, R, Bsel : datapath steering and strobes
//   halted, illegal     : sticky stop flag, one-cycle unsupported-opcode pulse
//   o_state             : current FSM state, for observation
// The control word is registered when leaving DECODE, so strobes only appear
// in EXECUTE/MEM; they are cleared on every exit from those states.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [3:0]  status,
  output logic        instr_req,
  output logic [63:0] pc,
  output logic [63:0] k,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  FS,
  output logic        dataMux,
  output logic        regW,
  output logic        ramW,
  output logic        R,
  output logic        Bsel,
  output logic        halted,
  output logic        illegal,
  output state_t      o_state
);

  state_t      r_state;
  logic [31:0] r_ir;
  logic [63:0] r_pc;
  ctrl_t       r_ctrl;
  logic        r_illegal;
  logic        r_halted;

  ctrl_t       w_ctrl;
  logic        w_illegal;
  logic        w_unused_status;

  assign w_unused_status = ^status[3:1];

  instr_decode u_instr_decode (
    .i_ir      (r_ir),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_ctrl.flow == FLOW_HALT) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
            r_state   <= EXECUTE;
          end
        end
        EXECUTE: begin
          r_illegal <= 1'b0;
          if (r_ctrl.flow == FLOW_LOAD) begin
            // Write-back phase: read data from RAM into Rt (DA already Rt).
            r_ctrl.mem_r    <= 1'b1;
            r_ctrl.data_mux <= 1'b1;
            r_ctrl.reg_w    <= 1'b1;
            r_state         <= MEM;
          end else begin
            r_ctrl.mem_r    <= 1'b0;
            r_ctrl.data_mux <= 1'b0;
            r_ctrl.reg_w    <= 1'b0;
            r_ctrl.ram_w    <= 1'b0;
            r_state         <= FETCH;
            // Z is sampled on the same edge that ends EXECUTE.
            if (r_ctrl.flow == FLOW_B || (r_ctrl.flow == FLOW_CBZ && status[0]))
              r_pc <= r_pc + r_ctrl.k;
            else
              r_pc <= r_pc + 64'd4;
          end
        end
        MEM: begin
          r_ctrl.mem_r    <= 1'b0;
          r_ctrl.data_mux <= 1'b0;
          r_ctrl.reg_w    <= 1'b0;
          r_ctrl.ram_w    <= 1'b0;
          r_pc            <= r_pc + 64'd4;
          r_state         <= FETCH;
        end
        HALT: r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign instr_req = (r_state == FETCH);
  assign pc        = r_pc;
  assign k         = r_ctrl.k;
  assign DA        = r_ctrl.da;
  assign SA        = r_ctrl.sa;
  assign SB        = r_ctrl.sb;
  assign FS        = r_ctrl.fs;
  assign dataMux   = r_ctrl.data_mux;
  assign regW      = r_ctrl.reg_w;
  assign ramW      = r_ctrl.ram_w;
  assign R         = r_ctrl.mem_r;
  assign Bsel      = r_ctrl.b_sel;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign o_state   = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a table of hand-computed vectors, randomized
// instructions checked against an arithmetic reference model, and hand-written
// sequences for idle fetch, reset during MEM, and HALT.
module tb_control_unit;
  import control_unit_pkg::*;

  // Opcode values written independently of the design package.
  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [9:0]  T_ADDI = 10'b1001000100;
  localparam logic [9:0]  T_SUBI = 10'b1101000100;

  // care bits: [5]=k [4]=FS [3]=Bsel [2]=DA [1]=SA [0]=SB
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic        reg_w, ram_w, mem_r, ill, load, b_sel;
    logic [5:0]  care;
    logic [4:0]  da, sa, sb, fs;
    logic [63:0] k, pc_delta;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0;
  logic [3:0]  status = 4'd0;
  logic        instr_req, dataMux, regW, ramW, R, Bsel, halted, illegal;
  logic [63:0] pc, k;
  logic [4:0]  DA, SA, SB, FS;
  state_t      o_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_pc = 64'd0;
  vec_t        vecs[$];

  control_unit dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .status(status), .instr_req(instr_req), .pc(pc), .k(k), .DA(DA), .SA(SA),
    .SB(SB), .FS(FS), .dataMux(dataMux), .regW(regW), .ramW(ramW), .R(R),
    .Bsel(Bsel), .halted(halted), .illegal(illegal), .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_pc = 64'd0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [3:0] st,
                              input logic rw, input logic mw, input logic r,
                              input logic ill, input logic load, input logic [5:0] care,
                              input logic bs, input logic [4:0] da, input logic [4:0] sa,
                              input logic [4:0] sb, input logic [4:0] fs,
                              input logic [63:0] kv, input logic [63:0] dlt);
    vec_t v;
    v.instr = ins; v.status = st; v.reg_w = rw; v.ram_w = mw; v.mem_r = r;
    v.ill = ill; v.load = load; v.care = care; v.b_sel = bs; v.da = da;
    v.sa = sa; v.sb = sb; v.fs = fs; v.k = kv; v.pc_delta = dlt;
    return v;
  endfunction

  // ---------------- stimulus encoders ----------------
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [18:0] imm, input logic [4:0] rt);
    return {8'b10110100, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  // ---------------- reference model ----------------
  function automatic vec_t model(input logic [31:0] w, input logic [3:0] st);
    vec_t   v;
    longint off;
    logic [10:0] op11;
    op11 = w[31:21];
    v = mk(w, st, 0, 0, 0, 0, 0, 6'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd4);
    if (op11 == T_ADD || op11 == T_SUB || op11 == T_AND || op11 == T_ORR) begin
      v.reg_w = 1; v.care = 6'b011111;
      v.da = w[4:0]; v.sa = w[9:5]; v.sb = w[20:16];
      v.fs = (op11 == T_ADD) ? 5'b01000 : (op11 == T_SUB) ? 5'b01001 :
             (op11 == T_AND) ? 5'b00000 : 5'b00001;
    end else if (w[31:22] == T_ADDI || w[31:22] == T_SUBI) begin
      v.reg_w = 1; v.b_sel = 1; v.care = 6'b111110;
      v.da = w[4:0]; v.sa = w[9:5];
      v.k = 64'(w[21:10]);
      v.fs = (w[31:22] == T_ADDI) ? 5'b01000 : 5'b01001;
    end else if (op11 == T_LDUR || op11 == T_STUR) begin
      off = longint'(w[20:12]);
      if (off >= 256) off = off - 512;
      v.k = off; v.fs = 5'b01000; v.b_sel = 1; v.sa = w[9:5];
      if (op11 == T_LDUR) begin
        v.mem_r = 1; v.load = 1; v.da = w[4:0]; v.care = 6'b111010;
      end else begin
        v.ram_w = 1; v.sb = w[4:0]; v.care = 6'b111011;
      end
    end else if (w[31:24] == 8'b10110100) begin
      v.sb = w[4:0]; v.fs = 5'b00100; v.b_sel = 0; v.care = 6'b011001;
      off = longint'(w[23:5]);
      if (off >= 2**18) off = off - 2**19;
      if (st[0]) v.pc_delta = off * 4;
    end else if (w[31:26] == 6'b000101) begin
      off = longint'(w[25:0]);
      if (off >= 2**25) off = off - 2**26;
      v.pc_delta = off * 4;
    end else begin
      v.ill = 1;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    int unsigned kind;
    logic [4:0]  a, b, c;
    a = 5'($urandom()); b = 5'($urandom()); c = 5'($urandom());
    kind = $urandom_range(0, 10);
    case (kind)
      0: return enc_r(T_ADD, a, b, c);
      1: return enc_r(T_SUB, a, b, c);
      2: return enc_r(T_AND, a, b, c);
      3: return enc_r(T_ORR, a, b, c);
      4: return enc_i(T_ADDI, 12'($urandom()), b, c);
      5: return enc_i(T_SUBI, 12'($urandom()), b, c);
      6: return enc_d(T_LDUR, 9'($urandom()), b, c);
      7: return enc_d(T_STUR, 9'($urandom()), b, c);
      8: return enc_cb(19'($urandom()), c);
      9: return enc_b(26'($urandom()));
      default: return {6'b000000, 26'($urandom()) | 26'd1};
    endcase
  endfunction

  // ---------------- driver: one instruction through the pipeline ----------------
  task automatic apply(input vec_t v);
    instr = v.instr; status = v.status; instr_valid = 1'b1;
    tick();
    // junk with valid high while decoding must be ignored
    instr = $urandom(); instr_valid = 1'b1;
    chk("dec_state", 64'(o_state), 64'(DECODE));
    chk("dec_strobes", {regW, ramW, R}, 0);
    tick();
    instr_valid = 1'b0;
    chk("exe_state", 64'(o_state), 64'(EXECUTE));
    chk("exe_regW", regW, v.reg_w);
    chk("exe_ramW", ramW, v.ram_w);
    chk("exe_R", R, v.mem_r);
    chk("exe_dataMux", dataMux, 0);
    chk("exe_illegal", illegal, v.ill);
    if (v.care[5]) chk("exe_k", k, v.k);
    if (v.care[4]) chk("exe_FS", FS, v.fs);
    if (v.care[3]) chk("exe_Bsel", Bsel, v.b_sel);
    if (v.care[2]) chk("exe_DA", DA, v.da);
    if (v.care[1]) chk("exe_SA", SA, v.sa);
    if (v.care[0]) chk("exe_SB", SB, v.sb);
    tick();
    if (v.load) begin
      chk("mem_state", 64'(o_state), 64'(MEM));
      chk("mem_R", R, 1);
      chk("mem_dataMux", dataMux, 1);
      chk("mem_regW", regW, 1);
      chk("mem_ramW", ramW, 0);
      chk("mem_DA", DA, v.da);
      chk("mem_illegal", illegal, 0);
      tick();
    end
    exp_pc = exp_pc + v.pc_delta;
    chk("ret_state", 64'(o_state), 64'(FETCH));
    chk("ret_pc", pc, exp_pc);
    chk("ret_strobes", {regW, ramW, R, dataMux, illegal}, 0);
    chk("ret_instr_req", instr_req, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      instr = $urandom(); instr_valid = 1'b0;
      tick();
      chk("idle_state", 64'(o_state), 64'(FETCH));
      chk("idle_req", instr_req, 1);
      chk("idle_pc", pc, exp_pc);
      chk("idle_strobes", {regW, ramW, R}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got_halt;

    // Table of hand-computed vectors; pc walks 0,4,8,12,16,28,16,20,...
    vecs.push_back(mk(enc_r(T_ADD, 2, 1, 3), 4'h0, 1,0,0,0,0, 6'b011111, 0, 3, 1, 2, 5'b01000, 64'd0, 64'd4));
    vecs.push_back(mk(enc_r(T_SUB, 9, 8, 7), 4'h1, 1,0,0,0,0, 6'b011111, 0, 7, 8, 9, 5'b01001, 64'd0, 64'd4));
    vecs.push_back(mk(enc_r(T_AND, 12, 11, 10), 4'h0, 1,0,0,0,0, 6'b011111, 0, 10, 11, 12, 5'b00000, 64'd0, 64'd4));
    vecs.push_back(mk(enc_r(T_ORR, 30, 0, 31), 4'h0, 1,0,0,0,0, 6'b011111, 0, 31, 0, 30, 5'b00001, 64'd0, 64'd4));
    vecs.push_back(mk(enc_cb(19'd3, 4), 4'b0001, 0,0,0,0,0, 6'b011001, 0, 0, 0, 4, 5'b00100, 64'd0, 64'd12));
    vecs.push_back(mk(enc_b(26'h3FF_FFFD), 4'h0, 0,0,0,0,0, 6'b0, 0, 0, 0, 0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF4));
    vecs.push_back(mk(enc_cb(19'd3, 4), 4'b0000, 0,0,0,0,0, 6'b011001, 0, 0, 0, 4, 5'b00100, 64'd0, 64'd4));
    vecs.push_back(mk(enc_d(T_LDUR, 9'h1F8, 0, 5), 4'h0, 0,0,1,0,1, 6'b111010, 1, 5, 0, 0, 5'b01000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd4));
    vecs.push_back(mk(enc_d(T_STUR, 9'd16, 2, 6), 4'h0, 0,1,0,0,0, 6'b111011, 1, 0, 2, 6, 5'b01000, 64'd16, 64'd4));
    vecs.push_back(mk(enc_i(T_ADDI, 12'hFFF, 2, 1), 4'h0, 1,0,0,0,0, 6'b111110, 1, 1, 2, 0, 5'b01000, 64'd4095, 64'd4));
    vecs.push_back(mk(enc_i(T_SUBI, 12'h800, 4, 3), 4'h0, 1,0,0,0,0, 6'b111110, 1, 3, 4, 0, 5'b01001, 64'h800, 64'd4));
    vecs.push_back(mk(32'hFFFF_FFFF, 4'h0, 0,0,0,1,0, 6'b0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd4));
    vecs.push_back(mk(enc_b(26'h3FF_FFF5), 4'h0, 0,0,0,0,0, 6'b0, 0, 0, 0, 0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFD4));
    vecs.push_back(mk(enc_cb(19'd2, 0), 4'b1111, 0,0,0,0,0, 6'b011001, 0, 0, 0, 0, 5'b00100, 64'd0, 64'd8));
    vecs.push_back(mk(enc_cb(19'h7FFFF, 1), 4'b1110, 0,0,0,0,0, 6'b011001, 0, 0, 0, 1, 5'b00100, 64'd0, 64'd4));
    vecs.push_back(mk(32'h0000_0001, 4'h0, 0,0,0,1,0, 6'b0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd4));

    // Reset values
    do_reset();
    chk("rst_state", 64'(o_state), 64'(FETCH));
    chk("rst_pc", pc, 64'd0);
    chk("rst_k", k, 64'd0);
    chk("rst_sel", {DA, SA, SB, FS}, 0);
    chk("rst_flags", {dataMux, regW, ramW, R, Bsel, halted, illegal}, 0);
    chk("rst_instr_req", instr_req, 1);

    // instr_valid held low for 5 cycles
    idle(5);

    // Table vectors (pc wraps through zero near the end)
    foreach (vecs[i]) apply(vecs[i]);

    // Randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 2));
      apply(model(rand_instr(), 4'($urandom())));
    end

    // Reset asserted during the MEM cycle of LDUR
    instr = enc_d(T_LDUR, 9'h1F8, 0, 5); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("rmem_in_mem", 64'(o_state), 64'(MEM));
    reset = 1'b1; instr_valid = 1'b1;
    tick();
    chk("rmem_regW", regW, 0);
    chk("rmem_strobes", {ramW, R, dataMux}, 0);
    chk("rmem_pc", pc, 64'd0);
    chk("rmem_state", 64'(o_state), 64'(FETCH));
    reset = 1'b0; instr_valid = 1'b0;
    exp_pc = 64'd0;

    // HALT: one ADD first so the frozen pc is non-zero
    apply(model(enc_r(T_ADD, 2, 1, 3), 4'h0));
    instr = 32'd0; instr_valid = 1'b1;
    got_halt = 1'b0;
    for (int i = 0; i < 10 && !got_halt; i++) begin
      tick();
      instr_valid = 1'b0;
      got_halt = halted;
    end
    chk("halt_reached", got_halt, 1);
    for (int i = 0; i < 5; i++) begin
      instr = $urandom(); instr_valid = 1'b1;
      tick();
      chk("halt_flag", halted, 1);
      chk("halt_state", 64'(o_state), 64'(HALT));
      chk("halt_req", instr_req, 0);
      chk("halt_pc", pc, exp_pc);
      chk("halt_strobes", {regW, ramW, R}, 0);
    end
    reset = 1'b1; instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    exp_pc = 64'd0;
    chk("unhalt_pc", pc, 64'd0);
    chk("unhalt_state", 64'(o_state), 64'(FETCH));
    chk("unhalt_flag", halted, 0);
    apply(model(enc_i(T_ADDI, 12'd7, 1, 2), 4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; sampled on clock rising edge.
REQ-004 instr  in  32  instruction word from instruction ROM.
REQ-005 instr_valid  in  1  instr is valid this cycle.
REQ-006 status  in  4  datapath flags {V,C,N,Z}; Z = bit 0.
REQ-007 instr_req  out  1  request for the instruction at pc.
REQ-008 pc  out  64  program counter, byte address.
REQ-009 k  out  64  sign-/zero-extended immediate or offset to the datapath.
REQ-010 DA, SA, SB  out  5 each  destination, A-source and B-source register select.
REQ-011 FS  out  5  ALU function select.
REQ-012 dataMux  out  1  register write source; 1 = RAM, 0 = ALU.
REQ-013 regW, ramW, R  out  1 each  register write, RAM write and RAM read enable.
REQ-014 Bsel  out  1  ALU B operand; 1 = k, 0 = register SB.
REQ-015 halted  out  1  core stopped; high until reset.
REQ-016 illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM and HALT.
REQ-018 FETCH: instr_req=1; on instr_valid=1, instr SHALL latch into IR and go to DECODE; otherwise stay in FETCH indefinitely.
REQ-019 DECODE (1 cycle): IR fields SHALL be registered into the control word; all strobes (regW, ramW, R) SHALL be 0.
REQ-020 EXECUTE (1 cycle): the decoded control word SHALL drive the outputs.
  - ADD/SUB/AND/ORR: regW=1, Bsel=0, DA=Rd, SA=Rn, SB=Rm.
  - ADDI/SUBI: Bsel=1, k=zero-extended imm12, regW=1.
REQ-021 LDUR SHALL use EXECUTE then MEM.
  - EXECUTE: FS=ADD, Bsel=1, k=sign-extended imm9, R=1.
  - MEM: R=1, dataMux=1, regW=1, DA=Rt.
REQ-022 STUR SHALL use EXECUTE only: address as for LDUR, SB=Rt, ramW=1, regW=0.
REQ-023 CBZ: EXECUTE with SB=Rt, FS=PASSB, Bsel=0.
  - If status[0]=1 in that cycle: pc += sign-extended imm19<<2.
  - Otherwise: pc += 4.
REQ-024 B: pc += sign-extended imm26<<2; no strobes asserted.
REQ-025 All other instructions: pc += 4, applied on leaving the final state (EXECUTE or MEM).
REQ-026 pc arithmetic SHALL be 64-bit modulo 2^64; wrap-around is permitted silently.
REQ-027 instr=32'h0000_0000 SHALL enter HALT.
  - halted=1, instr_req=0, all strobes 0, pc frozen.
REQ-028 Unsupported opcode SHALL be treated as NOP: illegal=1 for its EXECUTE cycle, pc += 4, no strobes.
REQ-029 Strobes SHALL be 0 in FETCH, DECODE and HALT; regW and ramW SHALL never both be 1.
REQ-030 instr_valid SHALL be ignored outside FETCH.

Reset
REQ-031 Reset SHALL force the following on the next edge:
  - state=FETCH, pc=0, IR=0.
  - k, DA, SA, SB, FS, dataMux, regW, ramW, R, Bsel, halted, illegal all = 0.
REQ-032 Reset SHALL override instr_valid and any in-flight instruction; no strobe SHALL be asserted in the cycle following reset assertion.
REQ-033 Reset SHALL be the only exit from HALT.

Structure
REQ-034 A shared package SHALL hold:
  - the state enum;
  - opcode constants (ADD, SUB, AND, ORR, ADDI, SUBI, LDUR, STUR, CBZ, B);
  - FS codes: AND=00000, ORR=00001, PASSB=00100, ADD=01000, SUB=01001.
REQ-035 One sub-module SHALL exist: instr_decode (combinational IR -> control word plus illegal flag), instantiated once.

Verification
REQ-036 Reset then ROM supplying ADD X3,X1,X2 with instr_valid high:
  - DECODE at cycle 2, EXECUTE at cycle 3.
  - EXECUTE drives regW=1, DA=3, SA=1, SB=2, FS=01000, Bsel=0.
  - pc=4 afterwards.
REQ-037 LDUR X5,[X0,#-8]:
  - EXECUTE: k=64'hFFFF_FFFF_FFFF_FFF8, R=1.
  - MEM: dataMux=1, regW=1, DA=5.
  - pc=+4.
REQ-038 CBZ X4,#3 at pc=16:
  - status=4'b0001 -> pc=28.
  - status=4'b0000 -> pc=20.
REQ-039 instr_valid held low for 5 cycles: instr_req stays 1, state FETCH, pc unchanged, no strobes.
REQ-040 instr=0 -> halted=1 permanently, instr_req=0; reset asserted in HALT -> pc=0, FETCH next cycle.
REQ-041 Reset asserted during the MEM cycle of LDUR: regW=0 in the following cycle, pc=0.
